// File: rtl/tt_um_priority_encoder.sv
// 16-to-4 priority encoder with a registered 8-bit result.
// Any 1 in {ui_in, uio_in} gives {4'h0, index}; all-zero input gives 8'hF0.
module tt_um_priority_encoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [7:0] NO_INPUT = 8'hF0;

    logic [15:0] in_vec;
    logic [7:0]  result_d;
    logic [7:0]  result_q;

    assign in_vec = {ui_in, uio_in};

    // Ascending scan: the last set bit found is the most significant one.
    always_comb begin
        result_d = NO_INPUT;
        for (int i = 0; i < 16; i++) begin
            if (in_vec[i]) begin
                result_d = {4'b0000, i[3:0]};
            end
        end
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            result_q <= NO_INPUT;
        end else if (ena) begin
            result_q <= result_d;
        end
    end

    assign uo_out  = result_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_priority_encoder.sv
// Self-checking bench for tt_um_priority_encoder using an expected-value queue.
module tb_tt_um_priority_encoder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    logic [7:0] model_q;

    tt_um_priority_encoder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_enc(input logic [15:0] v);
        int k;
        k = 15;
        while (k >= 0 && !v[k]) k--;
        if (k < 0) return 8'hF0;
        return 8'(k);
    endfunction

    // Drive one cycle of stimulus, push the expected register value, then
    // check it just after the capturing edge.
    task automatic step(input string tag, input logic r, input logic e,
                        input logic [7:0] u, input logic [7:0] l);
        logic [7:0] exp;
        string      t;
        rst_n  = r;
        ena    = e;
        ui_in  = u;
        uio_in = l;
        if (r)      model_q = 8'hF0;
        else if (e) model_q = ref_enc({u, l});
        exp_q.push_back(model_q);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        chk(t, uo_out, exp);
        chk({t, "_oe"}, uio_oe, 8'h00);
        chk({t, "_uio_out"}, uio_out, 8'h00);
    endtask

    initial begin
        logic [15:0] v;
        logic        e;
        model_q = 8'hF0;
        rst_n   = 1'b1;
        ena     = 1'b1;
        ui_in   = 8'hFF;
        uio_in  = 8'h00;

        step("reset0", 1'b1, 1'b1, 8'hFF, 8'h00);
        step("reset1", 1'b1, 1'b1, 8'hFF, 8'hFF);

        step("all_zero", 1'b0, 1'b1, 8'h00, 8'h00);
        step("upper_2A_F1", 1'b0, 1'b1, 8'b0010_1010, 8'hF1);
        step("all_ones", 1'b0, 1'b1, 8'hFF, 8'hFF);
        step("lower_bit0", 1'b0, 1'b1, 8'h00, 8'h01);
        step("lower_bit7", 1'b0, 1'b1, 8'h00, 8'h80);

        for (int i = 0; i < 16; i++) begin
            v = 16'h0001 << i;
            step($sformatf("walk%0d", i), 1'b0, 1'b1, v[15:8], v[7:0]);
        end

        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom);
            if (i % 4 == 1) v = v >> $urandom_range(15, 0);
            if (i % 11 == 5) v = 16'h0000;
            e = ($urandom_range(3, 0) != 0);
            step($sformatf("rand%0d", i), 1'b0, e, v[15:8], v[7:0]);
        end

        step("load05", 1'b0, 1'b1, 8'h00, 8'h20);
        step("hold_a", 1'b0, 1'b0, 8'h80, 8'h00);
        step("hold_b", 1'b0, 1'b0, 8'h00, 8'h00);
        step("hold_c", 1'b0, 1'b0, 8'h12, 8'h34);
        step("mid_reset", 1'b1, 1'b1, 8'hFF, 8'hFF);
        step("post_reset", 1'b0, 1'b1, 8'h04, 8'h00);
        step("reset_no_ena", 1'b1, 1'b0, 8'h40, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
